// File: rtl/spectrum_peak_detect.sv
// Per-frame spectrum statistics: running peak magnitude/bin, total energy and a
// threshold flag, published once per completed frame of NBINS valid bins.
module spectrum_peak_detect #(
    parameter int WIDTH   = 16,
    parameter int NBINS   = 256,
    parameter int BIN_LOG = $clog2(NBINS),
    parameter int SKIP_DC = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_mag_valid,
    input  logic [WIDTH-1:0]         i_mag,
    input  logic [WIDTH-1:0]         i_thresh,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [WIDTH-1:0]         o_peak_mag,
    output logic [BIN_LOG-1:0]       o_peak_bin,
    output logic [WIDTH+BIN_LOG-1:0] o_energy,
    output logic                     o_detect
);

    localparam int EW = WIDTH + BIN_LOG;

    // state  | meaning
    // S_IDLE | waiting for start, samples ignored
    // S_RUN  | collecting bins of the current frame
    // S_DONE | one-cycle result strobe, start here chains the next frame
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BIN_LOG-1:0]   r_bin_cnt;
    logic [WIDTH-1:0]     r_run_max;
    logic [BIN_LOG-1:0]   r_run_bin;
    logic [EW-1:0]        r_acc;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_take;
    logic [EW-1:0]        w_acc_sum;
    logic [WIDTH-1:0]     w_max_new;
    logic [BIN_LOG-1:0]   w_bin_new;

    // A start in RUN aborts, so a coincident sample is never accepted.
    assign w_accept  = (r_state == S_RUN) && i_mag_valid && !i_start;
    assign w_last    = w_accept && (r_bin_cnt == BIN_LOG'(NBINS - 1));
    assign w_acc_sum = r_acc + EW'(i_mag);

    // With DC skipped, bin 1 is the first eligible bin and always seeds the max,
    // so an all-zero frame reports bin 1.
    always_comb begin
        w_take = 1'b0;
        if (w_accept) begin
            if (SKIP_DC != 0) begin
                if (r_bin_cnt == BIN_LOG'(1))
                    w_take = 1'b1;
                else if (r_bin_cnt != '0)
                    w_take = (i_mag > r_run_max);
            end else begin
                w_take = (i_mag > r_run_max);
            end
        end
    end

    assign w_max_new = w_take ? i_mag     : r_run_max;
    assign w_bin_new = w_take ? r_bin_cnt : r_run_bin;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                if (i_start)
                    w_next = S_RUN;
                else if (w_last)
                    w_next = S_DONE;
            end
            S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bin_cnt <= '0;
            r_run_max <= '0;
            r_run_bin <= '0;
            r_acc     <= '0;
        end else if (i_start) begin
            r_bin_cnt <= '0;
            r_run_max <= '0;
            r_run_bin <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            r_bin_cnt <= r_bin_cnt + BIN_LOG'(1);
            r_run_max <= w_max_new;
            r_run_bin <= w_bin_new;
            r_acc     <= w_acc_sum;
        end
    end

    // Results load on the edge that accepts the final bin, so they are valid
    // throughout the DONE cycle and hold until the next completed frame.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_peak_mag <= '0;
            o_peak_bin <= '0;
            o_energy   <= '0;
            o_detect   <= 1'b0;
        end else if (w_last) begin
            o_peak_mag <= w_max_new;
            o_peak_bin <= w_bin_new;
            o_energy   <= w_acc_sum;
            o_detect   <= (w_max_new >= i_thresh);
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);

endmodule
